// File: rtl/gsm_alert_arbiter.sv
// gsm_alert_arbiter: shares one GSM SMS sender between the video-motion and
// temperature alarm sources. Rising edges on the requests are latched as
// pending events. Grants go round-robin, one message at a time. Each message
// gets a one-cycle start, a bounded wait for completion, and a hold-off gap.
module gsm_alert_arbiter #(
  parameter int unsigned HOLD_OFF_CYC = 32'd24_000_000,
  parameter int unsigned TIMEOUT_CYC  = 32'd240_000_000,
  parameter int unsigned CW           = 32'd28
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic       req_video,
  input  logic       req_temp,
  input  logic       gsm_busy,
  input  logic       gsm_done,
  output logic       gsm_start,
  output logic [1:0] gsm_sel,
  output logic [1:0] pend,
  output logic       err_timeout,
  output logic       led_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  // The wait check looks one count ahead so that err_timeout becomes visible
  // exactly TIMEOUT_CYC cycles after the ISSUE cycle.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 32'd2);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_OFF_CYC - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO     = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE      = CW'(32'd1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    req_q, req_d;
  logic [1:0]    pend_q, pend_d;
  logic          last_q, last_d;   // 1: temp was granted last, 0: video
  logic          start_q, start_d;
  logic [1:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [1:0]    rise_s;
  logic [1:0]    grant_s;

  assign rise_s      = {req_temp, req_video} & ~req_q;
  assign gsm_start   = start_q;
  assign gsm_sel     = sel_q;
  assign pend        = pend_q;
  assign err_timeout = err_q;
  assign led_busy    = busy_q;

  // Next-state logic: grant selection, message sequencing and pending bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    grant_s = 2'b00;
    req_d   = {req_temp, req_video};
    case (state_q)
      S_IDLE: begin
        if ((pend_q != 2'b00) && !gsm_busy) begin
          if (pend_q == 2'b01) begin
            grant_s = 2'b01;
          end else if (pend_q == 2'b10) begin
            grant_s = 2'b10;
          end else begin
            // Both pending: serve the channel that did not go last.
            grant_s = last_q ? 2'b01 : 2'b10;
          end
          sel_d   = grant_s;
          last_d  = grant_s[1];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          sel_d = 2'b00;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_ZERO;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion outranks a coinciding timeout.
        if (gsm_done) begin
          cnt_d   = CNT_ZERO;
          state_d = S_HOLDOFF;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = S_HOLDOFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = CNT_ZERO;
          sel_d   = 2'b00;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        sel_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
    // A new edge on the grant edge survives the clear, so it stays pending.
    pend_d = (pend_q & ~grant_s) | rise_s;
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any in-flight grant at once.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      req_q   <= 2'b00;
      pend_q  <= 2'b00;
      last_q  <= 1'b1;
      start_q <= 1'b0;
      sel_q   <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_gsm_alert_arbiter.sv
// Self-checking bench for gsm_alert_arbiter (HOLD_OFF_CYC=16, TIMEOUT_CYC=64).
// Expected start pulses and timeout pulses are queued when stimulus is driven
// and compared every cycle against the DUT outputs.
module tb_gsm_alert_arbiter;

  localparam int H = 16;
  localparam int T = 64;

  logic       clk_24m   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_video = 1'b0;
  logic       req_temp  = 1'b0;
  logic       gsm_busy  = 1'b0;
  logic       gsm_done  = 1'b0;
  logic       gsm_start;
  logic [1:0] gsm_sel;
  logic [1:0] pend;
  logic       err_timeout;
  logic       led_busy;

  gsm_alert_arbiter #(
    .HOLD_OFF_CYC(16),
    .TIMEOUT_CYC (64),
    .CW          (8)
  ) dut (
    .clk_24m    (clk_24m),
    .rst_n      (rst_n),
    .req_video  (req_video),
    .req_temp   (req_temp),
    .gsm_busy   (gsm_busy),
    .gsm_done   (gsm_done),
    .gsm_start  (gsm_start),
    .gsm_sel    (gsm_sel),
    .pend       (pend),
    .err_timeout(err_timeout),
    .led_busy   (led_busy)
  );

  always #5 clk_24m = ~clk_24m;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    int         dly;   // cycles from start to gsm_done; 0 means never
    logic [1:0] sel1;
    logic [1:0] sel2;
  } vec_t;

  exp_t start_q[$];
  int   err_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_start(input int c, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    start_q.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge and score start/timeout.
  task automatic tick();
    logic exp_start;
    logic exp_err;
    exp_t e;
    @(posedge clk_24m);
    #1;
    cyc++;
    exp_start = (start_q.size() > 0) && (start_q[0].cyc == cyc);
    check("gsm_start", 32'(gsm_start), 32'(exp_start));
    if (exp_start) begin
      e = start_q.pop_front();
      check("start_sel", 32'(gsm_sel), 32'(e.sel));
    end
    exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
    check("err_timeout", 32'(err_timeout), 32'(exp_err));
    if (exp_err) void'(err_q.pop_front());
  endtask

  // Called in the ISSUE cycle s; finishes on the first IDLE cycle.
  task automatic serve(input int s, input int dly, input logic [1:0] sel);
    int d;
    int idle;
    if (dly > 0) begin
      d    = s + dly;
      idle = d + H + 1;
      while (cyc < d) tick();
      gsm_done = 1'b1;
      tick();
      gsm_done = 1'b0;
    end else begin
      err_q.push_back(s + T);
      idle = s + T + H;
    end
    while (cyc < idle - 1) tick();
    check("busy_in_holdoff", 32'(led_busy), 32'd1);
    check("sel_held", 32'(gsm_sel), 32'(sel));
    tick();
    check("busy_idle", 32'(led_busy), 32'd0);
    check("sel_idle", 32'(gsm_sel), 32'd0);
  endtask

  task automatic run_case(input vec_t v);
    int t;
    int i1;
    t         = cyc;
    req_video = v.req[0];
    req_temp  = v.req[1];
    tick();
    check("pend_set", 32'(pend), 32'(v.req));
    req_video = 1'b0;
    req_temp  = 1'b0;
    push_start(t + 2, v.sel1);
    tick();
    check("pend_after_grant1", 32'(pend), 32'(v.req & ~v.sel1));
    check("busy_with_start", 32'(led_busy), 32'd1);
    serve(t + 2, v.dly, v.sel1);
    if (v.req == 2'b11) begin
      i1 = cyc;
      push_start(i1 + 1, v.sel2);
      tick();
      check("pend_after_grant2", 32'(pend), 32'd0);
      serve(i1 + 1, v.dly, v.sel2);
    end
    // A stray done while idle must not cause anything.
    gsm_done = 1'b1;
    tick();
    gsm_done = 1'b0;
    repeat (3) tick();
    check("start_queue_empty", 32'(start_q.size()), 32'd0);
    check("err_queue_empty", 32'(err_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    int   t;
    int   b;
    int   c;
    int   i;

    vecs[0] = '{2'b11, 20, 2'b01, 2'b10};  // simultaneous: video first
    vecs[1] = '{2'b10,  7, 2'b10, 2'b00};  // temp alone
    vecs[2] = '{2'b11,  3, 2'b01, 2'b10};  // after temp: video first
    vecs[3] = '{2'b01,  9, 2'b01, 2'b00};  // video alone
    vecs[4] = '{2'b11,  4, 2'b10, 2'b01};  // after video: temp first
    vecs[5] = '{2'b10,  0, 2'b10, 2'b00};  // timeout
    vecs[6] = '{2'b01, 63, 2'b01, 2'b00};  // done coincides with timeout
    vecs[7] = '{2'b01,  1, 2'b01, 2'b00};  // fastest done

    // Reset values.
    repeat (3) tick();
    check("rst_start", 32'(gsm_start), 32'd0);
    check("rst_sel", 32'(gsm_sel), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_busy", 32'(led_busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(led_busy), 32'd0);

    for (int k = 0; k < 8; k++) run_case(vecs[k]);

    // Busy blocking, then re-arm on the grant edge and during WAIT_DONE.
    t         = cyc;
    req_video = 1'b1;
    tick();
    req_video = 1'b0;
    gsm_busy  = 1'b1;
    check("busy_pend_set", 32'(pend), 32'd1);
    repeat (30) tick();
    check("pend_while_busy", 32'(pend), 32'd1);
    check("idle_while_busy", 32'(led_busy), 32'd0);
    b         = cyc;
    gsm_busy  = 1'b0;
    req_video = 1'b1;
    push_start(b + 1, 2'b01);
    tick();
    req_video = 1'b0;
    check("pend_set_wins", 32'(pend), 32'd1);
    tick();
    req_video = 1'b1;
    tick();
    req_video = 1'b0;
    check("pend_merged", 32'(pend), 32'd1);
    serve(b + 1, 10, 2'b01);
    i = cyc;
    push_start(i + 1, 2'b01);
    tick();
    check("pend_rearm_cleared", 32'(pend), 32'd0);
    serve(i + 1, 5, 2'b01);
    repeat (10) tick();
    check("rearm_queue_empty", 32'(start_q.size()), 32'd0);

    // Asynchronous reset in the middle of WAIT_DONE.
    t         = cyc;
    req_video = 1'b1;
    tick();
    req_video = 1'b0;
    push_start(t + 2, 2'b01);
    tick();
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_start", 32'(gsm_start), 32'd0);
    check("arst_sel", 32'(gsm_sel), 32'd0);
    check("arst_pend", 32'(pend), 32'd0);
    check("arst_err", 32'(err_timeout), 32'd0);
    check("arst_busy", 32'(led_busy), 32'd0);
    req_temp = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    c     = cyc;
    push_start(c + 2, 2'b10);
    tick();
    check("post_rst_pend", 32'(pend), 32'd2);
    tick();
    serve(c + 2, 6, 2'b10);
    req_temp = 1'b0;
    repeat (5) tick();
    check("final_queue_empty", 32'(start_q.size()), 32'd0);
    check("final_pend", 32'(pend), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
